// File: rtl/rv_muldiv_gen.sv
// RISC-V M-extension multiply/divide unit; build option RV_MULDIV_DIVZ_FAST_EN.
// Multiply: MUL_LAT-cycle pipeline, never stalls. Divide: XLEN/DIV_BITS+1 cycles issue-to-cmpl.
// Divide issues only when idle with rdy=1; ops offered while busy are dropped and the core stalls.
package rv_muldiv_pkg;
  typedef enum logic [3:0] {
    ALU_NOP    = 4'd0,
    ALU_MUL    = 4'd1,
    ALU_MULH   = 4'd2,
    ALU_MULHSU = 4'd3,
    ALU_MULHU  = 4'd4,
    ALU_DIV    = 4'd5,
    ALU_DIVU   = 4'd6,
    ALU_REM    = 4'd7,
    ALU_REMU   = 4'd8
  } alu_t;
endpackage

module rv_muldiv_gen
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 2,
  parameter int MUL_LAT  = 1
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            rdy,
  input  alu_t            alu,
  input  logic [XLEN-1:0] rrd1,
  input  logic [XLEN-1:0] rrd2,
  output logic [XLEN-1:0] rwdat,
  output logic [XLEN-1:0] rwdatx,
  output logic            cmpl,
  output logic            mulop,
  output logic            busy
);
  localparam int NITER = XLEN / DIV_BITS;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------- multiply ----------------
  logic                  ma_sgn, mb_sgn;
  logic [2*XLEN-1:0]     ma, mb, prod;
  logic [XLEN-1:0]       mres;
  logic [XLEN-1:0]       mpipe [MUL_LAT];

  assign mulop = (alu == ALU_MUL) || (alu == ALU_MULH) || (alu == ALU_MULHSU) || (alu == ALU_MULHU);

  // Low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product are exact for every variant.
  always_comb begin
    ma_sgn = ((alu == ALU_MULH) || (alu == ALU_MULHSU)) && rrd1[XLEN-1];
    mb_sgn = (alu == ALU_MULH) && rrd2[XLEN-1];
    ma     = {{XLEN{ma_sgn}}, rrd1};
    mb     = {{XLEN{mb_sgn}}, rrd2};
    prod   = ma * mb;
    case (alu)
      ALU_MUL:                         mres = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: mres = prod[2*XLEN-1:XLEN];
      default:                         mres = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mres;
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  assign rwdatx = mpipe[MUL_LAT-1];

  // ---------------- divide ----------------
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state, state_n;

  logic [2*XLEN-1:0] rem_q, dv_q, rem_n, dv_n;
  logic [XLEN-1:0]   quo_q, quo_n, a_abs, b_abs, q_fin, r_fin, res_calc, res_fast;
  logic [CW-1:0]     cnt_q;
  logic              qneg_q, rneg_q, isrem_q, divz_q, ovf_q;
  logic              div_req, is_signed, is_rem_in, a_neg, b_neg, divz_in, ovf_in, fast_hit;

  always_comb begin
    div_req   = rdy && ((alu == ALU_DIV) || (alu == ALU_DIVU) || (alu == ALU_REM) || (alu == ALU_REMU));
    is_signed = (alu == ALU_DIV) || (alu == ALU_REM);
    is_rem_in = (alu == ALU_REM) || (alu == ALU_REMU);
    a_neg     = is_signed && rrd1[XLEN-1];
    b_neg     = is_signed && rrd2[XLEN-1];
    a_abs     = a_neg ? -rrd1 : rrd1;
    b_abs     = b_neg ? -rrd2 : rrd2;
    divz_in   = (rrd2 == '0);
    ovf_in    = is_signed && (rrd1 == SMIN) && (rrd2 == '1);
    res_fast  = is_rem_in ? (divz_in ? rrd1 : '0) : (divz_in ? '1 : SMIN);
`ifdef RV_MULDIV_DIVZ_FAST_EN
    fast_hit  = divz_in || ovf_in;
`else
    fast_hit  = 1'b0;
`endif
  end

  // DIV_BITS restoring steps: divisor walks right from b<<(XLEN-1) down to b.
  always_comb begin
    rem_n = rem_q;
    dv_n  = dv_q;
    quo_n = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      dv_n = dv_n >> 1;
      if (rem_n >= dv_n) begin
        rem_n = rem_n - dv_n;
        quo_n = {quo_n[XLEN-2:0], 1'b1};
      end else begin
        quo_n = {quo_n[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_fin = qneg_q ? -quo_n : quo_n;
    r_fin = rneg_q ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
    if (divz_q) q_fin = '1;
    if (ovf_q) begin
      q_fin = SMIN;
      r_fin = '0;
    end
    res_calc = isrem_q ? r_fin : q_fin;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (div_req) state_n = fast_hit ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CW'(1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      state   <= S_IDLE;
      rwdat   <= '0;
      rem_q   <= '0;
      dv_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && div_req) begin
        rem_q   <= {{XLEN{1'b0}}, a_abs};
        dv_q    <= {b_abs, {XLEN{1'b0}}};
        quo_q   <= '0;
        cnt_q   <= CW'(NITER);
        qneg_q  <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
        isrem_q <= is_rem_in;
        divz_q  <= divz_in;
        ovf_q   <= ovf_in;
        if (fast_hit) rwdat <= res_fast;
      end else if (state == S_CALC) begin
        rem_q <= rem_n;
        dv_q  <= dv_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) rwdat <= res_calc;
      end
    end
  end

  assign cmpl = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rv_muldiv_gen.sv
// Self-checking bench for rv_muldiv_gen: directed ISA corner cases plus random ops vs. an arithmetic model.
`timescale 1ns/1ps
module tb_rv_muldiv_gen;
  import rv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic        rdy = 1'b0;
  alu_t        alu = ALU_NOP;
  logic [31:0] rrd1 = '0, rrd2 = '0;
  logic [31:0] rwdat, rwdatx, rwdat2, rwdatx2;
  logic        cmpl, mulop, busy, cmpl2, mulop2, busy2;

  int errors = 0;
  int checks = 0;

  alu_t        mq_op[$];
  logic [31:0] mq_a[$], mq_b[$];

  always #5 clk = ~clk;

  rv_muldiv_gen #(.XLEN(32), .DIV_BITS(2), .MUL_LAT(1)) dut (
    .clk(clk), .xreset(xreset), .rdy(rdy), .alu(alu), .rrd1(rrd1), .rrd2(rrd2),
    .rwdat(rwdat), .rwdatx(rwdatx), .cmpl(cmpl), .mulop(mulop), .busy(busy));

  rv_muldiv_gen #(.XLEN(32), .DIV_BITS(2), .MUL_LAT(2)) dut2 (
    .clk(clk), .xreset(xreset), .rdy(rdy), .alu(alu), .rrd1(rrd1), .rrd2(rrd2),
    .rwdat(rwdat2), .rwdatx(rwdatx2), .cmpl(cmpl2), .mulop(mulop2), .busy(busy2));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] div_ref(input alu_t op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input alu_t op, input logic [31:0] a, input logic [31:0] b);
`ifdef RV_MULDIV_DIVZ_FAST_EN
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 17;
  endfunction

  function automatic logic [31:0] mul_ref(input alu_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      ALU_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      ALU_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      ALU_MULHSU: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
      ALU_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      default:    return 32'h0;
    endcase
  endfunction

  // Caller is at #1 after an edge with the divider idle.
  task automatic div_run(input alu_t op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat, bc, elat;
    bit got;
    exp  = div_ref(op, a, b);
    elat = exp_lat(op, a, b);
    alu = op; rrd1 = a; rrd2 = b; rdy = 1'b1;
    step();
    alu = ALU_NOP; rdy = 1'b0;
    lat = 0; bc = 0; got = 1'b0;
    while (!got && lat < 40) begin
      lat++;
      if (busy) bc++;
      if (cmpl) got = 1'b1;
      else step();
    end
    chk({tag, " cmpl seen"}, 64'(got), 64'd1);
    chk({tag, " rwdat"}, 64'(rwdat), 64'(exp));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy cycles"}, 64'(bc), 64'(elat));
    step();
    chk({tag, " cmpl/busy drop"}, {62'h0, cmpl, busy}, 64'h0);
    chk({tag, " rwdat hold"}, 64'(rwdat), 64'(exp));
  endtask

  task automatic mul_push(input alu_t op, input logic [31:0] a, input logic [31:0] b);
    mq_op.push_back(op);
    mq_a.push_back(a);
    mq_b.push_back(b);
  endtask

  // Requires the two previously sampled ops to be non-multiply (pipelines hold 0).
  task automatic mul_run(input string tag);
    logic [31:0] h[$];
    int n;
    n = mq_op.size();
    h.push_back(32'h0);
    h.push_back(32'h0);
    for (int j = 0; j < n + 2; j++) begin
      chk($sformatf("%s lat1 #%0d", tag, j), 64'(rwdatx), 64'(h[j+1]));
      chk($sformatf("%s lat2 #%0d", tag, j), 64'(rwdatx2), 64'(h[j]));
      if (j < n) begin
        alu = mq_op[j]; rrd1 = mq_a[j]; rrd2 = mq_b[j];
        h.push_back(mul_ref(mq_op[j], mq_a[j], mq_b[j]));
      end else begin
        alu = ALU_NOP;
        h.push_back(32'h0);
      end
      step();
    end
    mq_op.delete(); mq_a.delete(); mq_b.delete();
  endtask

  initial begin
    alu_t dops[4];
    alu_t mops[5];
    alu_t op;
    logic [31:0] a, b, exp;
    bit got;
    dops = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    mops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_NOP};

    repeat (3) step();
    chk("reset rwdat/rwdatx", {rwdat, rwdatx}, 64'h0);
    chk("reset cmpl/busy", {62'h0, cmpl, busy}, 64'h0);
    chk("reset dut2 outputs", {rwdat2, rwdatx2}, 64'h0);
    xreset = 1'b1;
    step();

    alu = ALU_MULHU; #1;
    chk("mulop MULHU", 64'(mulop), 64'd1);
    alu = ALU_DIVU; #1;
    chk("mulop DIVU", 64'(mulop), 64'd0);
    alu = ALU_NOP;
    step();

    div_run(ALU_DIVU, 32'd100, 32'd7, "DIVU 100/7");
    div_run(ALU_REMU, 32'd100, 32'd7, "REMU 100/7");
    div_run(ALU_DIV, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    div_run(ALU_REM, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
    div_run(ALU_DIV, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2");
    div_run(ALU_REM, 32'd7, 32'hFFFF_FFFE, "REM 7/-2");
    div_run(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
    div_run(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
    div_run(ALU_DIVU, 32'd5, 32'd0, "DIVU 5/0");
    div_run(ALU_REMU, 32'd5, 32'd0, "REMU 5/0");
    div_run(ALU_DIV, 32'hFFFF_FFFB, 32'd0, "DIV -5/0");
    div_run(ALU_REM, 32'hFFFF_FFFB, 32'd0, "REM -5/0");

    step();
    mul_push(ALU_MULH, 32'h8000_0000, 32'h8000_0000);
    mul_push(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_push(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_push(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_run("mul directed");

    for (int i = 0; i < 20; i++) begin
      op = dops[$urandom_range(0, 3)];
      a = $urandom();
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        default: b = $urandom() >> $urandom_range(0, 28);
      endcase
      div_run(op, a, b, $sformatf("rand div %0d op=%0d a=%h b=%h", i, op, a, b));
    end

    step();
    for (int i = 0; i < 24; i++) mul_push(mops[$urandom_range(0, 4)], $urandom(), $urandom());
    mul_run("mul random");

    // Multiplies flow while a divide is busy; a divide offered mid-flight is dropped.
    alu = ALU_DIVU; rrd1 = 32'd1000; rrd2 = 32'd7; rdy = 1'b1;
    step();
    alu = ALU_NOP; rdy = 1'b0;
    step();
    step();
    for (int i = 0; i < 6; i++) mul_push(mops[$urandom_range(0, 3)], $urandom(), $urandom());
    mul_run("mul during div");
    alu = ALU_DIV; rrd1 = 32'd50; rrd2 = 32'd5; rdy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmpl) got = 1'b1;
      else step();
    end
    chk("busy div cmpl seen", 64'(got), 64'd1);
    chk("busy div rwdat", 64'(rwdat), 64'(div_ref(ALU_DIVU, 32'd1000, 32'd7)));
    alu = ALU_NOP; rdy = 1'b0;
    step();
    chk("ignored div not issued", 64'(busy), 64'd0);

    alu = ALU_DIVU; rrd1 = 32'd1000; rrd2 = 32'd3; rdy = 1'b1;
    step();
    alu = ALU_NOP; rdy = 1'b0;
    repeat (4) step();
    xreset = 1'b0;
    step();
    chk("abort cmpl/busy", {62'h0, cmpl, busy}, 64'h0);
    chk("abort rwdat cleared", 64'(rwdat), 64'h0);
    xreset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cmpl) got = 1'b1;
      step();
    end
    chk("abort no late cmpl", 64'(got), 64'd0);
    div_run(ALU_DIVU, 32'd9, 32'd3, "DIVU 9/3 after abort");
    exp = 32'd3;
    chk("DIVU 9/3 literal", 64'(rwdat), 64'(exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_gen.md
# rv_muldiv_gen

Parametrised multiply/divide unit for the rv32emc ALU stage. It implements RISC-V M-extension semantics at a configurable datapath width.
- Multiply is a fixed-latency pipeline; its result leaves on `rwdatx`.
- Divide/remainder is a multi-cycle iterative engine retiring `DIV_BITS` quotient bits per cycle; its result leaves on `rwdat` with a `cmpl` pulse.
- Divide-by-zero and signed-overflow results always match the ISA definition.

## Interface
Parameters:
- `XLEN`, 32: operand/result width (16, 32 or 64).
- `DIV_BITS`, 2: quotient bits per iteration (1, 2 or 4); must divide `XLEN`.
- `MUL_LAT`, 1: multiply pipeline depth (1 or 2).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `xreset`  in  1: synchronous, active-low reset.
- `rdy`  in  1: pipeline advance; qualifies divide issue.
- `alu`  in  `alu_t`: operation (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; others = no-op).
- `rrd1`  in  `XLEN`: operand a (dividend/multiplicand).
- `rrd2`  in  `XLEN`: operand b (divisor/multiplier).
- `rwdat`  out  `XLEN`: divide/remainder result, valid while `cmpl`=1.
- `rwdatx`  out  `XLEN`: multiply result, `MUL_LAT` cycles after the op.
- `cmpl`  out  1: one-cycle divide-done pulse.
- `mulop`  out  1: combinational; 1 when `alu` is a multiply op.
- `busy`  out  1: 1 while the divider is not Idle.

## Operation
Multiply:
- The pipeline advances every cycle and is independent of `rdy`.
- The op and operands presented in cycle T produce `rwdatx` in cycle T+`MUL_LAT`.
- MUL: low `XLEN` bits of u×u.
- MULH: high `XLEN` bits of s×s.
- MULHSU: high `XLEN` bits of s×u.
- MULHU: high `XLEN` bits of u×u.
- A non-multiply op yields `rwdatx`=0.
- Full-precision product is 2·`XLEN` bits; MULHSU uses an (`XLEN`+1)-bit signed zero-extended b.

Divide FSM, states Idle, Calc, Done:
- **Idle → Calc:** when `rdy`=1 and `alu` ∈ {DIV, DIVU, REM, REMU}. On this transition the FSM latches:
  - |a| and |b| (signed ops) or a and b (unsigned ops);
  - quotient sign = a[msb]^b[msb] and remainder sign = a[msb] (both 0 for unsigned);
  - op kind and zero/overflow flags.
- **Calc:** performs `XLEN`/`DIV_BITS` iterations. Each iteration is `DIV_BITS` restoring steps: shift the divisor right, compare, conditionally subtract, shift in the quotient bit.
- **Calc → Done:** after the last iteration. On this transition the final result is registered into `rwdat`.
- **Done:** `cmpl`=1 for this one cycle, then → Idle.
- Divide ops presented while `busy`=1 are ignored; the core stalls.
- `rwdat` holds its value until the next Done.

Result correction at the registered output:
- Negated quotient/remainder when the respective sign flag is set.
- Divisor 0: quotient = all ones for both DIV and DIVU; remainder = dividend unchanged.
- DIV with −2^(`XLEN`−1) / −1: quotient = −2^(`XLEN`−1), remainder = 0.

## Timing
- Reset values: `rwdat`=0, `rwdatx`=0, `cmpl`=0, `busy`=0, FSM=Idle, multiply pipeline cleared to no-op.
- `xreset` low mid-divide aborts the operation; no `cmpl` is ever produced for it.
- Divide latency, issue edge T to `cmpl` high:
  - N+1 cycles, where N = `XLEN`/`DIV_BITS` (17 for 32/2).
  - `busy` is high from T+1 through the Done cycle inclusive.
- The earliest next issue is the Done cycle's edge+1 (the cycle after `cmpl`).
- `mulop` has zero latency.
- A multiply issued while the divider is busy still completes normally.

## Configuration
Macro `RV_MULDIV_DIVZ_FAST_EN`:
- **Defined:** at issue, divisor==0 or signed overflow skips Calc. The FSM goes Idle → Done, so `cmpl` is high at T+1 with the corrected result.
- **Undefined:** these cases run the full N iterations. Results are identical; only latency differs.

## Test plan
- DIVU 100/7 and REMU 100/7, `XLEN`=32, `DIV_BITS`=2 → `rwdat`=14 and 2; `cmpl` exactly 17 cycles after issue; `busy` high 17 cycles.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0xFFFFFFFB/0 → 0xFFFFFFFF; REM 0xFFFFFFFB/0 → 0xFFFFFFFB. `cmpl` at T+1 with the macro, T+17 without.
- Back-to-back multiplies at `MUL_LAT`=1 and 2:
  - MULH 0x80000000·0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
  - MUL 0xFFFFFFFF² → 1.
  - Each result appears exactly `MUL_LAT` cycles after its op.
- `xreset` low at T+5 of a DIVU → next cycle `busy`=0 and `cmpl`=0 with no later pulse; a new DIVU 9/3 is accepted and gives 3.
